// File: rtl/status_register_unit_pkg.sv
// Shared processor definitions: status flag layout and widths used by the
// status register unit and the ID-stage condition-check logic.
package status_register_unit_pkg;

    localparam int STATUS_W = 4;
    localparam int COUNT_W  = 8;

    // Bit positions of the NZCV flags within a status word.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef logic [STATUS_W-1:0] status_t;

endpackage : status_register_unit_pkg

// File: rtl/status_register_unit_sat_counter.sv
// Saturating up-counter: advances by one per enabled cycle and sticks at
// all-ones instead of wrapping back to zero.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Count enabled cycles, holding once the maximum value is reached.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register
        // samples pre-edge values and simulation matches the synthesized flops.
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule : sat_counter

// File: rtl/status_register_unit.sv
// NZCV status register with same-cycle write-through forwarding to the ID
// stage, EXE-over-MSR per-bit write merging, a sticky overflow flag and a
// saturating count of committed ALU flag writes.
module status_register_unit
    import status_register_unit_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze,
    input  logic                flush,
    input  logic                exe_valid,
    input  logic                exe_s,
    input  logic [STATUS_W-1:0] exe_flag_mask,
    input  logic [STATUS_W-1:0] alu_status,
    input  logic                msr_valid,
    input  logic [STATUS_W-1:0] msr_data,
    input  logic                sticky_clr,
    output logic [STATUS_W-1:0] status_out,
    output logic [STATUS_W-1:0] status_reg,
    output logic                sticky_v,
    output logic [COUNT_W-1:0]  update_count
);

    status_t w_next;
    status_t r_status;
    logic    w_alu_we;
    logic    w_msr_we;
    logic    w_v_set;
    logic    w_sticky_clr;
    logic    w_count_inc;
    logic    r_sticky_v;

    // Merge ALU and MSR writes into the next flag value and forward it.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        w_alu_we = exe_valid & exe_s & ~flush & ~freeze;
        w_msr_we = msr_valid & ~freeze;
        w_next   = r_status;
        // The EXE instruction is younger, so its masked bits beat the MSR write.
        for (int i = 0; i < STATUS_W; i++) begin
            if (w_alu_we && exe_flag_mask[i]) begin
                w_next[i] = alu_status[i];
            end else if (w_msr_we) begin
                w_next[i] = msr_data[i];
            end
        end
        // V only counts as set when a write source actually produced it.
        w_v_set      = ((w_alu_we & exe_flag_mask[FLAG_V]) | w_msr_we) & w_next[FLAG_V];
        w_sticky_clr = sticky_clr & ~freeze;
        w_count_inc  = w_alu_we & (|exe_flag_mask);
        // Writes about to be discarded by reset must not be forwarded.
        status_out   = rst ? r_status : w_next;
    end

    // Architectural flags and sticky overflow; reset beats everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_status   <= '0;
            r_sticky_v <= 1'b0;
        end else begin
            r_status <= w_next;
            if (w_v_set) begin
                r_sticky_v <= 1'b1;
            end else if (w_sticky_clr) begin
                r_sticky_v <= 1'b0;
            end
        end
    end

    sat_counter #(
        .WIDTH (COUNT_W)
    ) u_update_count (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_count_inc),
        .o_count (update_count)
    );

    assign status_reg = r_status;
    assign sticky_v   = r_sticky_v;

endmodule : status_register_unit

// File: tb/tb_status_register_unit.sv
// Self-checking bench for status_register_unit: a driver applies stimulus
// shortly after each rising edge and pushes the reference model's expected
// outputs; a monitor pops and compares them on the falling edge.
module tb_status_register_unit;
    import status_register_unit_pkg::*;

    typedef struct packed {
        logic       rst;
        logic       freeze;
        logic       flush;
        logic       exe_valid;
        logic       exe_s;
        logic [3:0] mask;
        logic [3:0] alu;
        logic       msr_valid;
        logic [3:0] msr_data;
        logic       sticky_clr;
    } stim_t;

    typedef struct packed {
        logic [3:0] status_out;
        logic [3:0] status_reg;
        logic       sticky_v;
        logic [7:0] count;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       freeze;
    logic       flush;
    logic       exe_valid;
    logic       exe_s;
    logic [3:0] exe_flag_mask;
    logic [3:0] alu_status;
    logic       msr_valid;
    logic [3:0] msr_data;
    logic       sticky_clr;
    logic [3:0] status_out;
    logic [3:0] status_reg;
    logic       sticky_v;
    logic [7:0] update_count;

    int n_checks = 0;
    int n_errors = 0;

    exp_t exp_q[$];

    // Reference model state (architectural view).
    logic [3:0] m_flags;
    logic       m_sticky;
    int         m_count;

    status_register_unit dut (
        .clk           (clk),
        .rst           (rst),
        .freeze        (freeze),
        .flush         (flush),
        .exe_valid     (exe_valid),
        .exe_s         (exe_s),
        .exe_flag_mask (exe_flag_mask),
        .alu_status    (alu_status),
        .msr_valid     (msr_valid),
        .msr_data      (msr_data),
        .sticky_clr    (sticky_clr),
        .status_out    (status_out),
        .status_reg    (status_reg),
        .sticky_v      (sticky_v),
        .update_count  (update_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    // Drive one cycle of stimulus, record the model's expectation and advance the model.
    task automatic drive(input stim_t s);
        logic       alu_we;
        logic       msr_we;
        logic [3:0] alu_bits;
        logic [3:0] base;
        logic [3:0] nxt;
        exp_t       e;
        @(posedge clk);
        #1;
        rst           = s.rst;
        freeze        = s.freeze;
        flush         = s.flush;
        exe_valid     = s.exe_valid;
        exe_s         = s.exe_s;
        exe_flag_mask = s.mask;
        alu_status    = s.alu;
        msr_valid     = s.msr_valid;
        msr_data      = s.msr_data;
        sticky_clr    = s.sticky_clr;

        alu_we   = s.exe_valid && s.exe_s && !s.flush && !s.freeze;
        msr_we   = s.msr_valid && !s.freeze;
        alu_bits = alu_we ? s.mask : 4'b0000;
        base     = msr_we ? s.msr_data : m_flags;
        nxt      = (alu_bits & s.alu) | (~alu_bits & base);

        e.status_out = s.rst ? m_flags : nxt;
        e.status_reg = m_flags;
        e.sticky_v   = m_sticky;
        e.count      = 8'(m_count);
        exp_q.push_back(e);

        if (s.rst) begin
            m_flags  = 4'b0000;
            m_sticky = 1'b0;
            m_count  = 0;
        end else begin
            m_flags = nxt;
            if ((alu_bits[FLAG_V] || msr_we) && nxt[FLAG_V]) m_sticky = 1'b1;
            else if (s.sticky_clr && !s.freeze) m_sticky = 1'b0;
            if (alu_we && alu_bits != 4'b0000 && m_count < 255) m_count++;
        end
    endtask

    // Directed spot check against fixed values, taken in the current cycle.
    task automatic expect_now(input string name, input logic [3:0] so, input logic [3:0] sr,
                              input logic sv, input logic [7:0] cnt);
        @(negedge clk);
        check({name, ".status_out"}, 32'(status_out), 32'(so));
        check({name, ".status_reg"}, 32'(status_reg), 32'(sr));
        check({name, ".sticky_v"}, 32'(sticky_v), 32'(sv));
        check({name, ".update_count"}, 32'(update_count), 32'(cnt));
    endtask

    function automatic stim_t alu_wr(input logic [3:0] mask, input logic [3:0] alu);
        stim_t s;
        s = '0;
        s.exe_valid = 1'b1;
        s.exe_s     = 1'b1;
        s.mask      = mask;
        s.alu       = alu;
        return s;
    endfunction

    // Scoreboard monitor: compare every pending expectation against the DUT.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("sb.status_out", 32'(status_out), 32'(e.status_out));
            check("sb.status_reg", 32'(status_reg), 32'(e.status_reg));
            check("sb.sticky_v", 32'(sticky_v), 32'(e.sticky_v));
            check("sb.update_count", 32'(update_count), 32'(e.count));
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        stim_t s;
        rst = 1'b1; freeze = 1'b0; flush = 1'b0; exe_valid = 1'b0; exe_s = 1'b0;
        exe_flag_mask = '0; alu_status = '0; msr_valid = 1'b0; msr_data = '0; sticky_clr = 1'b0;
        m_flags = '0; m_sticky = 1'b0; m_count = 0;
        repeat (2) @(posedge clk);

        // Reset state, then first ALU write forwarded in the same cycle.
        drive(idle());
        expect_now("reset", 4'b0000, 4'b0000, 1'b0, 8'd0);
        drive(alu_wr(4'hF, 4'b0100));
        expect_now("alu_fwd", 4'b0100, 4'b0000, 1'b0, 8'd0);
        drive(idle());
        expect_now("alu_commit", 4'b0100, 4'b0100, 1'b0, 8'd1);

        // EXE bits override a same-cycle MSR write; unmasked bits take msr_data.
        s = idle(); s.msr_valid = 1'b1; s.msr_data = 4'b1111;
        drive(s);
        s = alu_wr(4'b1100, 4'b0000); s.msr_valid = 1'b1; s.msr_data = 4'b0101;
        drive(s);
        expect_now("merge_fwd", 4'b0001, 4'b1111, 1'b1, 8'd1);
        drive(idle());
        expect_now("merge_commit", 4'b0001, 4'b0001, 1'b1, 8'd2);

        // Clear sticky, then a flushed ALU write must change nothing.
        s = idle(); s.sticky_clr = 1'b1;
        drive(s);
        s = alu_wr(4'hF, 4'b0001); s.flush = 1'b1;
        drive(s);
        expect_now("flush", 4'b0001, 4'b0001, 1'b0, 8'd2);
        drive(idle());
        expect_now("flush_after", 4'b0001, 4'b0001, 1'b0, 8'd2);

        // Freeze holds everything for three cycles, then the write goes through.
        for (int i = 0; i < 3; i++) begin
            s = alu_wr(4'hF, 4'b1000); s.msr_valid = 1'b1; s.msr_data = 4'b0010;
            s.freeze = 1'b1; s.sticky_clr = 1'b1;
            drive(s);
            expect_now("freeze", 4'b0001, 4'b0001, 1'b0, 8'd2);
        end
        s = alu_wr(4'hF, 4'b1000); s.msr_valid = 1'b1; s.msr_data = 4'b0010;
        drive(s);
        drive(idle());
        expect_now("unfreeze", 4'b1000, 4'b1000, 1'b0, 8'd3);

        // Sticky V: set wins over same-cycle clear; clear alone clears.
        drive(alu_wr(4'b0001, 4'b0001));
        s = alu_wr(4'b0001, 4'b0001); s.sticky_clr = 1'b1;
        drive(s);
        expect_now("sticky_set", 4'b1001, 4'b1001, 1'b1, 8'd4);
        s = idle(); s.sticky_clr = 1'b1;
        drive(s);
        expect_now("sticky_win", 4'b1001, 4'b1001, 1'b1, 8'd5);
        drive(idle());
        expect_now("sticky_clr", 4'b1001, 4'b1001, 1'b0, 8'd5);

        // Randomized traffic checked only through the scoreboard.
        for (int i = 0; i < 400; i++) begin
            s.rst        = ($urandom_range(0, 49) == 0);
            s.freeze     = ($urandom_range(0, 5) == 0);
            s.flush      = ($urandom_range(0, 4) == 0);
            s.exe_valid  = ($urandom_range(0, 3) != 0);
            s.exe_s      = ($urandom_range(0, 2) != 0);
            s.mask       = 4'($urandom);
            s.alu        = 4'($urandom);
            s.msr_valid  = ($urandom_range(0, 3) == 0);
            s.msr_data   = 4'($urandom);
            s.sticky_clr = ($urandom_range(0, 4) == 0);
            drive(s);
        end

        // Saturation: reset, then 300 nonzero-mask ALU writes.
        s = idle(); s.rst = 1'b1;
        drive(s);
        for (int i = 0; i < 300; i++) begin
            drive(alu_wr(4'($urandom_range(1, 15)), 4'($urandom)));
        end
        s = alu_wr(4'hF, 4'b1111);
        drive(s);
        expect_now("saturate", 4'b1111, m_flags, m_sticky, 8'hFF);
        s = alu_wr(4'hF, 4'b1010); s.rst = 1'b1;
        drive(s);
        drive(idle());
        expect_now("rst_mid_burst", 4'b0000, 4'b0000, 1'b0, 8'd0);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) check("sb.drain", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_status_register_unit
